mux_scan_ctrl: RTL and testbench

Sequential scan controller wrapped around the 16:1 gate-level mux. It drives the mux select lines, waits for the select to settle, and samples the single-bit mux output. It assembles the 16 samples into a parallel word and also streams each bit out serially. It sits directly upstream of the mux (producing sel) and directly downstream of it (consuming y).

---
 rtl/mux_scan_ctrl_if.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between a scan host, the 16:1 mux and the mux scan controller.
// The slave view belongs to the controller; the master view belongs to whoever
// requests scans and supplies the mux output.
interface mux_scan_ctrl_if #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4
);
  logic             start;
  logic             cont;
  logic             y_in;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  capture;
  logic             ser_bit;
  logic             ser_valid;

  modport master (
    output start, cont, y_in,
    input  sel, busy, done, capture, ser_bit, ser_valid
  );

  modport slave (
    input  start, cont, y_in,
    output sel, busy, done, capture, ser_bit, ser_valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 16:1 mux: steps the select lines, lets each select
// settle, samples the mux output, builds a parallel word and streams each bit.
module mux_scan_ctrl #(
  parameter int N_CH       = 16,
  parameter int SEL_W      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // With no settle time the controller goes straight from select change to sampling.
  localparam state_t ST_AFTER_SEL = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  capture_q, capture_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;

  // Next-state and registered-output logic; capture is loaded on entry to DONE
  // (with the final sample merged in) so it is valid while done is high.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    shadow_d    = shadow_q;
    capture_d   = capture_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_AFTER_SEL;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        shadow_d[sel_q] = bus.y_in;
        ser_bit_d       = bus.y_in;
        ser_valid_d     = 1'b1;
        if (sel_q == SEL_LAST) begin
          capture_d = shadow_d;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          cnt_d   = CNT_RELOAD;
          state_d = ST_AFTER_SEL;
        end
      end

      ST_DONE: begin
        if (bus.cont) begin
          sel_d   = '0;
          cnt_d   = CNT_RELOAD;
          state_d = ST_AFTER_SEL;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shadow_q    <= '0;
      capture_q   <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shadow_q    <= shadow_d;
      capture_q   <= capture_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.capture   = capture_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_valid = ser_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: one instance with a one-cycle settle time for the
// single-scan cases and one with no settle time for continuous mode. Each
// instance sees a behavioural 16:1 mux built from a bench-held pattern word.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [15:0] pat_a;
  logic [15:0] pat_b;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [15:0] pattern;
    logic [15:0] exp_capture;
    int          glitch_t;
  } vec_t;

  vec_t vecs [4];

  mux_scan_ctrl_if #(.N_CH(16), .SEL_W(4)) if_a ();
  mux_scan_ctrl_if #(.N_CH(16), .SEL_W(4)) if_b ();

  mux_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE_CYC(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  mux_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE_CYC(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  // Behavioural mux: each instance reads its pattern bit at the current select.
  assign if_a.y_in = pat_a[if_a.sel];
  assign if_b.y_in = pat_b[if_b.sel];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic cont_v);
    rst_a      = rst_v;
    if_a.start = start_v;
    if_a.cont  = cont_v;
  endtask

  // One full scan on instance A, started at the next edge; t counts edges after accept.
  task automatic runScan(input logic [15:0] pat, input logic [15:0] exp_cap,
                         input logic [15:0] old_cap, input int glitch_t);
    int          sel_err   = 0;
    int          busy_err  = 0;
    int          cap_err   = 0;
    int          valid_err = 0;
    int          valid_cnt = 0;
    int          done_cnt  = 0;
    int          done_at   = -1;
    int          exp_sel;
    logic [15:0] stream;
    stream = ~exp_cap;
    pat_a  = pat;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("accept_busy", 32'(if_a.busy), 32'd1);
    checkOutput("accept_sel", 32'(if_a.sel), 32'd0);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      applyStimulus(1'b0, (glitch_t != 0) && (t == glitch_t), 1'b0);
      exp_sel = (t / 2 > 15) ? 15 : t / 2;
      if (32'(if_a.sel) !== 32'(exp_sel)) sel_err++;
      if (if_a.busy !== (t <= 32)) busy_err++;
      if (if_a.done === 1'b1) begin
        done_cnt++;
        done_at = t;
      end
      if (if_a.ser_valid === 1'b1) begin
        valid_cnt++;
        if ((t % 2 != 0) || (t > 32)) valid_err++;
        else stream[t / 2 - 1] = if_a.ser_bit;
      end
      if (if_a.capture !== ((t < 32) ? old_cap : exp_cap)) cap_err++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sel_steps", 32'(sel_err), 32'd0);
    checkOutput("busy_window", 32'(busy_err), 32'd0);
    checkOutput("capture_timing", 32'(cap_err), 32'd0);
    checkOutput("ser_valid_timing", 32'(valid_err), 32'd0);
    checkOutput("ser_valid_count", 32'(valid_cnt), 32'd16);
    checkOutput("ser_stream", 32'(stream), 32'(exp_cap));
    checkOutput("done_count", 32'(done_cnt), 32'd1);
    checkOutput("done_cycle", 32'(done_at), 32'd32);
    checkOutput("final_capture", 32'(if_a.capture), 32'(exp_cap));
  endtask

  initial begin
    int          done_cnt;
    int          done_times [4];
    int          busy_err;
    int          cap_err;
    int          valid_cnt;
    logic [15:0] prev_cap;

    vecs[0] = '{pattern: 16'b1010_1010_1010_1010, exp_capture: 16'hAAAA, glitch_t: 0};
    vecs[1] = '{pattern: 16'b1111_0000_1111_0000, exp_capture: 16'hF0F0, glitch_t: 0};
    vecs[2] = '{pattern: 16'h8001,                exp_capture: 16'h8001, glitch_t: 14};
    vecs[3] = '{pattern: 16'h1234,                exp_capture: 16'h1234, glitch_t: 32};

    pat_a = 16'h0000;
    pat_b = 16'hF0F0;
    rst_b = 1'b1;
    if_b.start = 1'b0;
    if_b.cont  = 1'b0;

    // Reset held two cycles with start high: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sel", 32'(if_a.sel), 32'd0);
    checkOutput("rst_busy", 32'(if_a.busy), 32'd0);
    checkOutput("rst_done", 32'(if_a.done), 32'd0);
    checkOutput("rst_capture", 32'(if_a.capture), 32'h0000);
    checkOutput("rst_ser_valid", 32'(if_a.ser_valid), 32'd0);
    checkOutput("rst_ser_bit", 32'(if_a.ser_bit), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_busy", 32'(if_a.busy), 32'd0);
    checkOutput("idle_sel", 32'(if_a.sel), 32'd0);

    // Table-driven full scans; capture must hold the previous word mid-scan.
    prev_cap = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      runScan(vecs[i].pattern, vecs[i].exp_capture, prev_cap, vecs[i].glitch_t);
      prev_cap = vecs[i].exp_capture;
    end

    // Reset in the middle of a scan (sel=5): partial word dropped, no done.
    pat_a = 16'hFFFF;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) @(negedge clk);
    checkOutput("pre_rst_sel", 32'(if_a.sel), 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_sel", 32'(if_a.sel), 32'd0);
    checkOutput("midrst_busy", 32'(if_a.busy), 32'd0);
    checkOutput("midrst_capture", 32'(if_a.capture), 32'h0000);
    checkOutput("midrst_ser_valid", 32'(if_a.ser_valid), 32'd0);
    done_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (if_a.done === 1'b1 || if_a.busy === 1'b1) done_cnt++;
    end
    checkOutput("midrst_quiet", 32'(done_cnt), 32'd0);
    runScan(16'h5A3C, 16'h5A3C, 16'h0000, 0);

    // Continuous mode on the zero-settle instance: done every 17 cycles.
    done_cnt  = 0;
    busy_err  = 0;
    cap_err   = 0;
    valid_cnt = 0;
    foreach (done_times[i]) done_times[i] = -1;
    if_b.cont  = 1'b1;
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      if (t == 55) if_b.cont = 1'b0;
      if (if_b.busy !== (t <= 67)) busy_err++;
      if (if_b.ser_valid === 1'b1) valid_cnt++;
      if (if_b.done === 1'b1) begin
        if (done_cnt < 4) done_times[done_cnt] = t;
        done_cnt++;
        if (if_b.capture !== 16'hF0F0) cap_err++;
      end else if (t < 16 && if_b.capture !== 16'h0000) begin
        cap_err++;
      end
      if (t == 16) checkOutput("cont_sel_last", 32'(if_b.sel), 32'd15);
      if (t == 17) checkOutput("cont_sel_wrap", 32'(if_b.sel), 32'd0);
    end
    checkOutput("cont_done_count", 32'(done_cnt), 32'd4);
    checkOutput("cont_done_0", 32'(done_times[0]), 32'd16);
    checkOutput("cont_done_1", 32'(done_times[1]), 32'd33);
    checkOutput("cont_done_2", 32'(done_times[2]), 32'd50);
    checkOutput("cont_done_3", 32'(done_times[3]), 32'd67);
    checkOutput("cont_busy", 32'(busy_err), 32'd0);
    checkOutput("cont_capture", 32'(cap_err), 32'd0);
    checkOutput("cont_valid_count", 32'(valid_cnt), 32'd64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
